// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with a double-buffered display
// value, optional leading-zero blanking and per-digit decimal points.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        load,
    input  logic [7:0]  dp,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_start
);

    localparam int unsigned         PW      = 20;
    localparam logic [PW-1:0]       TICK_AT = PW'(SCAN_DIV - 32'd1);
    localparam logic [2:0]          IDX_LAST = 3'd7;

    // Active-low segment pattern {G,F,E,D,C,B,A} for one hex nibble.
    function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Nibble i and everything above it, right-aligned.
    function automatic logic [31:0] upper_from(input logic [31:0] v, input logic [2:0] i);
        return v >> {i, 2'b00};
    endfunction

    // A digit other than digit 0 is a leading zero when it and all higher nibbles are zero.
    function automatic logic is_leading_zero(input logic [31:0] v, input logic [2:0] i);
        return (i != 3'd0) && (upper_from(v, i) == 32'd0);
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_q, disp_d;
    logic [31:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_start_q, frame_start_d;

    logic          tick_s;
    logic          wrap_s;
    logic [31:0]   upper_s;
    logic [3:0]    nib_s;
    logic          blank_s;

    assign tick_s = (presc_q == TICK_AT);
    assign wrap_s = tick_s && (idx_q == IDX_LAST);

    // Prescaler and digit index advance.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (tick_s) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Double buffer: the swap at the frame wrap consumes the old pend before any same-edge load.
    always_comb begin
        disp_d        = disp_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        frame_start_d = 1'b0;
        if (wrap_s) begin
            frame_start_d = 1'b1;
            if (pend_valid_q) begin
                disp_d       = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                disp_d       = disp_q;
            end
        end else begin
            frame_start_d = 1'b0;
        end
        if (load) begin
            pend_d       = data;
            pend_valid_d = 1'b1;
        end else begin
            pend_d       = pend_q;
        end
    end

    assign upper_s = upper_from(disp_d, idx_d);
    assign nib_s   = upper_s[3:0];
    assign blank_s = BLANK_LZ && is_leading_zero(disp_d, idx_d) && !dp[idx_d];

    // Outputs are recomputed only on a tick, from the post-edge index and buffer.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick_s) begin
            if (blank_s) begin
                an_d  = 8'hFF;
                seg_d = 8'hFF;
            end else begin
                an_d  = ~(8'h01 << idx_d);
                seg_d = {~dp[idx_d], hex_pattern(nib_s)};
            end
        end else begin
            an_d  = an_q;
            seg_d = seg_q;
        end
    end

    // State registers; reset darkens the display and discards both buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q       <= '0;
            idx_q         <= IDX_LAST;
            disp_q        <= 32'd0;
            pend_q        <= 32'd0;
            pend_valid_q  <= 1'b0;
            an_q          <= 8'hFF;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign SEG         = seg_q;
    assign AN          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized check of seg7_scan against an edge-counting reference model of the
// scan, double-buffer and blanking rules.
module tb_seg7_scan;

    localparam int unsigned DIV = 4;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        load;
    logic [7:0]  dp;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        frame_start;

    int n_vec;
    int n_bad;

    // Reference model state.
    int          m_edges;
    int          m_slot;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    bit          m_pv;
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    logic        m_fs;

    logic [6:0] hexpat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .load        (load),
        .dp          (dp),
        .SEG         (SEG),
        .AN          (AN),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_slot  = 7;
        m_disp  = 32'd0;
        m_pend  = 32'd0;
        m_pv    = 1'b0;
        m_an    = 8'hFF;
        m_seg   = 8'hFF;
        m_fs    = 1'b0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge(input logic ld, input logic [31:0] dat, input logic [7:0] dpv);
        bit   tick;
        logic [31:0] hi;
        m_edges++;
        tick = (m_edges % DIV) == 0;
        m_fs = 1'b0;
        if (tick) begin
            m_slot = (m_slot + 1) % 8;
            if (m_slot == 0) begin
                m_fs = 1'b1;
                if (m_pv) begin
                    m_disp = m_pend;
                    m_pv   = 1'b0;
                end
            end
        end
        if (ld) begin
            m_pend = dat;
            m_pv   = 1'b1;
        end
        if (tick) begin
            hi = m_disp >> (4 * m_slot);
            if (m_slot != 0 && hi == 32'd0 && !dpv[m_slot]) begin
                m_an  = 8'hFF;
                m_seg = 8'hFF;
            end else begin
                m_an  = 8'hFF ^ (8'h01 << m_slot);
                m_seg = {~dpv[m_slot], hexpat[hi[3:0]]};
            end
        end
    endtask

    task automatic step(input logic ld, input logic [31:0] dat, input logic [7:0] dpv);
        data = dat;
        load = ld;
        dp   = dpv;
        @(posedge clk);
        model_edge(ld, dat, dpv);
        #1;
        load = 1'b0;
        check_val("AN", {24'd0, AN}, {24'd0, m_an});
        check_val("SEG", {24'd0, SEG}, {24'd0, m_seg});
        check_val("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    endtask

    // True when the coming edge is the 7->0 frame wrap.
    function automatic bit next_is_wrap();
        return (((m_edges + 1) % DIV) == 0) && (m_slot == 7);
    endfunction

    task automatic run_to_slot(input int s);
        for (int k = 0; k < 8 * DIV + 2; k++) begin
            if (m_slot == s && ((m_edges % DIV) == 0)) break;
            step(1'b0, 32'd0, 8'h00);
        end
    endtask

    task automatic run_to_wrap(input logic [7:0] dpv);
        for (int k = 0; k < 8 * DIV + 2; k++) begin
            if (next_is_wrap()) break;
            step(1'b0, 32'd0, dpv);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        data  = 32'd0;
        load  = 1'b0;
        dp    = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_AN", {24'd0, AN}, 32'h0000_00FF);
        check_val("reset_SEG", {24'd0, SEG}, 32'h0000_00FF);
        check_val("reset_fs", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle frame after reset: only digit 0 lit, showing 0.
        for (int k = 0; k < 8 * DIV + 2; k++) step(1'b0, 32'd0, 8'h00);

        // Full eight-digit value.
        step(1'b1, 32'h1234ABCD, 8'h00);
        run_to_wrap(8'h00);
        for (int k = 0; k < 8 * DIV; k++) step(1'b0, 32'd0, 8'h00);

        // Leading zeros, then decimal point forcing the top digit lit.
        step(1'b1, 32'h0000_00F0, 8'h00);
        run_to_wrap(8'h00);
        for (int k = 0; k < 8 * DIV; k++) step(1'b0, 32'd0, 8'h00);
        run_to_wrap(8'h80);
        for (int k = 0; k < 8 * DIV; k++) step(1'b0, 32'd0, 8'h80);

        // Two loads mid-frame: only the last reaches the next frame.
        run_to_slot(3);
        step(1'b1, 32'h11111111, 8'h00);
        step(1'b1, 32'h22222222, 8'h00);
        run_to_wrap(8'h00);
        for (int k = 0; k < 8 * DIV; k++) step(1'b0, 32'd0, 8'h00);
        check_val("twos_seen", {24'd0, SEG}, 32'h0000_00A4);

        // Load coincident with the frame wrap while 5 is pending.
        step(1'b1, 32'h0000_0005, 8'h00);
        run_to_wrap(8'h00);
        step(1'b1, 32'h0000_0077, 8'h00);
        check_val("wrap_shows_5", {24'd0, SEG}, 32'h0000_0092);
        run_to_wrap(8'h00);
        step(1'b0, 32'd0, 8'h00);
        check_val("next_frame_77", {24'd0, SEG}, 32'h0000_00F8);

        // Reset at digit 3 with pending data: dark at once, pend discarded.
        run_to_slot(3);
        step(1'b1, 32'h9999_9999, 8'h00);
        rst = 1'b0;
        #1;
        check_val("midreset_AN", {24'd0, AN}, 32'h0000_00FF);
        check_val("midreset_SEG", {24'd0, SEG}, 32'h0000_00FF);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8 * DIV + 2; k++) step(1'b0, 32'd0, 8'h00);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            logic        ld;
            logic [31:0] dv;
            logic [7:0]  pv;
            ld = ($urandom_range(0, 5) == 0);
            dv = $urandom;
            dv = dv >> (4 * $urandom_range(0, 8));
            pv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(ld, dv, pv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
